// File: rtl/envelope_bank_if.sv
// Event/level bundle between the note allocator, envelope_bank and the per-voice VCAs.
// Also carries the shared ADSR parameter record type (package PARAMETER).
interface envelope_bank_if #(
    parameter int unsigned VOICES = 8,
    parameter int unsigned WIDTH  = 24
);
    logic                         sample_tick;
    logic [VOICES-1:0]            note_on;
    logic [VOICES-1:0]            note_off;
    logic                         busy;
    logic [VOICES-1:0][WIDTH-1:0] envelope;
    logic [VOICES-1:0]            envelope_end;

    modport master (
        output sample_tick,
        output note_on,
        output note_off,
        input  busy,
        input  envelope,
        input  envelope_end
    );

    modport slave (
        input  sample_tick,
        input  note_on,
        input  note_off,
        output busy,
        output envelope,
        output envelope_end
    );
endinterface

package PARAMETER;
    typedef struct packed {
        logic [6:0] attack_time;
        logic [6:0] decay_time;
        logic [6:0] sustain_level;
        logic [6:0] release_time;
    } parameter_t;
endpackage

// File: rtl/envelope_bank.sv
// Time-multiplexed ADSR envelope bank: one shared datapath services VOICES channels per sweep.
// Define ENVELOPE_BANK_HARD_RETRIGGER_EN to restart attack from zero on note_on (else legato).
module envelope_bank #(
    parameter int unsigned VOICES = 8,
    parameter int unsigned WIDTH  = 24
) (
    input  logic                  clock_50_000_000,
    input  logic                  reset_l,
    input  PARAMETER::parameter_t parameters,
    envelope_bank_if.slave        bus_io
);

    localparam int unsigned     IdxW    = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam logic [WIDTH:0]  Full    = {1'b0, {WIDTH{1'b1}}};
    localparam logic [IdxW-1:0] LastIdx = IdxW'(VOICES - 1);

    typedef enum logic {SwIdle, SwRun} sweep_e;
    typedef enum logic [2:0] {StIdle, StAttack, StDecay, StSustain, StRelease} voice_e;

    // Step size for a 7-bit time field; only its upper five bits select the shift.
    function automatic logic [WIDTH:0] step_of(input logic [4:0] shift);
        logic [WIDTH:0] s;
        s = Full >> shift;
        if (s == '0) begin
            s = (WIDTH + 1)'(1);
        end
        return s;
    endfunction

    sweep_e                       sweep_q, sweep_d;
    logic [IdxW-1:0]              idx_q, idx_d;
    voice_e                       state_q [VOICES];
    voice_e                       state_d [VOICES];
    logic [VOICES-1:0][WIDTH-1:0] env_q, env_d;
    logic [VOICES-1:0]            pend_on_q, pend_on_d;
    logic [VOICES-1:0]            pend_off_q, pend_off_d;
    logic [VOICES-1:0]            end_q, end_d;

    logic [WIDTH:0] step_a, step_d, step_r, target;
    logic [WIDTH:0] cur_lvl, sum, diff;
    logic [WIDTH-1:0] new_lvl;
    voice_e         cur_state, new_state;
    logic           svc_on, svc_off, fin;

    assign step_a = step_of(parameters.attack_time[6:2]);
    assign step_d = step_of(parameters.decay_time[6:2]);
    assign step_r = step_of(parameters.release_time[6:2]);

    always_comb begin
        if (parameters.sustain_level == 7'h7f) begin
            target = Full;
        end else begin
            target = {1'b0, parameters.sustain_level, {(WIDTH - 7){1'b0}}};
        end
    end

    // Sweep sequencer: a tick while running is dropped, not queued.
    always_comb begin
        sweep_d = sweep_q;
        idx_d   = idx_q;
        unique case (sweep_q)
            SwIdle: begin
                if (bus_io.sample_tick) begin
                    sweep_d = SwRun;
                    idx_d   = '0;
                end
            end
            SwRun: begin
                if (idx_q == LastIdx) begin
                    sweep_d = SwIdle;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            default: begin
                sweep_d = SwIdle;
                idx_d   = '0;
            end
        endcase
    end

    // Shared service datapath for the voice selected by idx_q.
    always_comb begin
        svc_on    = pend_on_q[idx_q];
        svc_off   = pend_off_q[idx_q];
        cur_state = state_q[idx_q];
        cur_lvl   = {1'b0, env_q[idx_q]};
        sum       = '0;
        diff      = '0;
        fin       = 1'b0;

        if (svc_on) begin
`ifdef ENVELOPE_BANK_HARD_RETRIGGER_EN
            cur_lvl = '0;
`endif
            cur_state = StAttack;
        end else if (svc_off && (cur_state inside {StAttack, StDecay, StSustain})) begin
            cur_state = StRelease;
        end

        new_state = cur_state;
        new_lvl   = cur_lvl[WIDTH-1:0];

        case (cur_state)
            StAttack: begin
                sum = cur_lvl + step_a;
                if (sum >= Full) begin
                    new_lvl   = Full[WIDTH-1:0];
                    new_state = StDecay;
                end else begin
                    new_lvl = sum[WIDTH-1:0];
                end
            end
            StDecay: begin
                diff = (cur_lvl > step_d) ? (cur_lvl - step_d) : '0;
                if (diff <= target) begin
                    new_lvl   = target[WIDTH-1:0];
                    new_state = StSustain;
                end else begin
                    new_lvl = diff[WIDTH-1:0];
                end
            end
            StSustain: begin
                new_lvl = target[WIDTH-1:0];
            end
            StRelease: begin
                if (cur_lvl <= step_r) begin
                    new_lvl   = '0;
                    new_state = StIdle;
                    fin       = 1'b1;
                end else begin
                    diff    = cur_lvl - step_r;
                    new_lvl = diff[WIDTH-1:0];
                end
            end
            default: begin
                new_lvl   = '0;
                new_state = StIdle;
            end
        endcase
    end

    // Pending events: on beats a simultaneous off; a pulse in the service cycle re-arms.
    always_comb begin
        state_d    = state_q;
        env_d      = env_q;
        end_d      = '0;
        pend_on_d  = pend_on_q | bus_io.note_on;
        pend_off_d = (pend_off_q | bus_io.note_off) & ~bus_io.note_on;
        if (sweep_q == SwRun) begin
            state_d[idx_q]    = new_state;
            env_d[idx_q]      = new_lvl;
            end_d[idx_q]      = fin;
            pend_on_d[idx_q]  = bus_io.note_on[idx_q];
            pend_off_d[idx_q] = bus_io.note_off[idx_q] & ~bus_io.note_on[idx_q];
        end
    end

    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            sweep_q    <= SwIdle;
            idx_q      <= '0;
            env_q      <= '0;
            pend_on_q  <= '0;
            pend_off_q <= '0;
            end_q      <= '0;
            for (int unsigned v = 0; v < VOICES; v++) begin
                state_q[v] <= StIdle;
            end
        end else begin
            sweep_q    <= sweep_d;
            idx_q      <= idx_d;
            env_q      <= env_d;
            pend_on_q  <= pend_on_d;
            pend_off_q <= pend_off_d;
            end_q      <= end_d;
            state_q    <= state_d;
        end
    end

    assign bus_io.busy         = (sweep_q == SwRun);
    assign bus_io.envelope     = env_q;
    assign bus_io.envelope_end = end_q;

endmodule

// File: tb/tb_envelope_bank.sv
// Scoreboard bench for envelope_bank: stimulus queues expected per-sweep levels, a monitor
// pops and compares them each time a sweep completes (busy falls).
module tb_envelope_bank;
    localparam int unsigned VOICES = 4;
    localparam int unsigned WIDTH  = 24;

    typedef logic [95:0] w_t;
    typedef struct {
        int unsigned      sweep;
        int unsigned      voice;
        logic [WIDTH-1:0] val;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst_l;
    PARAMETER::parameter_t prm;

    envelope_bank_if #(.VOICES(VOICES), .WIDTH(WIDTH)) bus ();

    envelope_bank #(.VOICES(VOICES), .WIDTH(WIDTH)) dut (
        .clock_50_000_000(clk),
        .reset_l         (rst_l),
        .parameters      (prm),
        .bus_io          (bus)
    );

    always #5 clk = ~clk;

    exp_t             scb_q[$];
    int               checks = 0;
    int               errors = 0;
    int unsigned      tick_n = 0;
    int unsigned      sweep_n = 0;
    int               end_cnt = 0;
    logic [WIDTH-1:0] end_lvl = '0;
    logic [WIDTH-1:0] end_prev = '0;
    logic [WIDTH-1:0] lvl_prev = '0;
    logic             busy_prev = 1'b0;

    task automatic chk(input string name, input w_t got, input w_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic expect_env(input int unsigned voice, input logic [WIDTH-1:0] val);
        exp_t e;
        e.sweep = tick_n + 1;
        e.voice = voice;
        e.val   = val;
        scb_q.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
        bus.sample_tick = 1'b1;
        @(negedge clk);
        bus.sample_tick = 1'b0;
        repeat (8) @(negedge clk);
        tick_n++;
    endtask

    task automatic pulse(input logic [VOICES-1:0] on, input logic [VOICES-1:0] off);
        @(negedge clk);
        bus.note_on  = on;
        bus.note_off = off;
        @(negedge clk);
        bus.note_on  = '0;
        bus.note_off = '0;
    endtask

    // Monitor: compare queued levels at each sweep completion, track end pulses on voice 0.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_l) begin
            busy_prev = 1'b0;
        end else begin
            if (busy_prev && !bus.busy) begin
                sweep_n++;
                while (scb_q.size() > 0 && scb_q[0].sweep == sweep_n) begin
                    e = scb_q.pop_front();
                    chk($sformatf("env[%0d]@sweep%0d", e.voice, e.sweep),
                        w_t'(bus.envelope[e.voice]), w_t'(e.val));
                end
            end
            busy_prev = bus.busy;
            if (bus.envelope_end[0]) begin
                end_cnt++;
                end_lvl  = bus.envelope[0];
                end_prev = lvl_prev;
            end
            lvl_prev = bus.envelope[0];
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_l           = 1'b0;
        bus.sample_tick = 1'b0;
        bus.note_on     = '0;
        bus.note_off    = '0;
        prm = '{attack_time: 7'h2A, decay_time: 7'h2B, sustain_level: 7'h6F,
                release_time: 7'h2F};
        repeat (3) @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);
        chk("reset_busy", w_t'(bus.busy), w_t'(0));
        chk("reset_env", w_t'(bus.envelope), w_t'(0));
        chk("reset_end", w_t'(bus.envelope_end), w_t'(0));

        // Attack to sustain on voice 0.
        pulse(4'b0001, 4'b0000);
        expect_env(0, 24'h003FFF);
        for (int unsigned v = 1; v < VOICES; v++) expect_env(v, '0);
        tick();
        repeat (1022) tick();
        expect_env(0, 24'hFFFC00);
        tick();
        expect_env(0, 24'hFFFFFF);
        for (int unsigned v = 1; v < VOICES; v++) expect_env(v, '0);
        tick();
        repeat (135) tick();
        expect_env(0, 24'hDE0087);
        tick();
        expect_env(0, 24'hDE0000);
        tick();
        repeat (7) tick();
        expect_env(0, 24'hDE0000);
        tick();

        // Release to zero with a single end pulse.
        pulse(4'b0000, 4'b0001);
        expect_env(0, 24'hDDE001);
        tick();
        expect_env(0, 24'hDDC002);
        tick();
        repeat (1773) tick();
        expect_env(0, 24'h0006F0);
        tick();
        chk("end_before_zero", w_t'(end_cnt), w_t'(0));
        expect_env(0, 24'h000000);
        tick();
        chk("end_pulse_count", w_t'(end_cnt), w_t'(1));
        chk("end_pulse_level", w_t'(end_lvl), w_t'(0));
        chk("end_pulse_prev_level", w_t'(end_prev), w_t'(24'h0006F0));
        pulse(4'b0000, 4'b0001);
        expect_env(0, 24'h000000);
        tick();
        expect_env(0, 24'h000000);
        tick();
        chk("end_after_idle_off", w_t'(end_cnt), w_t'(1));

        // Sweep timing, observed on voice 2; a tick at k+2 must be dropped.
        pulse(4'b0100, 4'b0000);
        expect_env(2, 24'h003FFF);
        @(negedge clk);
        bus.sample_tick = 1'b1;
        @(negedge clk);
        bus.sample_tick = 1'b0;
        chk("busy_k+1", w_t'(bus.busy), w_t'(1));
        @(negedge clk);
        chk("busy_k+2", w_t'(bus.busy), w_t'(1));
        bus.sample_tick = 1'b1;
        @(negedge clk);
        bus.sample_tick = 1'b0;
        chk("busy_k+3", w_t'(bus.busy), w_t'(1));
        chk("v2_at_k+3", w_t'(bus.envelope[2]), w_t'(0));
        @(negedge clk);
        chk("busy_k+4", w_t'(bus.busy), w_t'(1));
        chk("v2_at_k+4", w_t'(bus.envelope[2]), w_t'(24'h003FFF));
        @(negedge clk);
        chk("busy_k+5", w_t'(bus.busy), w_t'(0));
        @(negedge clk);
        chk("busy_k+6", w_t'(bus.busy), w_t'(0));
        repeat (4) @(negedge clk);
        tick_n++;

        // Simultaneous on/off on voice 1: on wins.
        pulse(4'b0010, 4'b0010);
        expect_env(1, 24'h003FFF);
        tick();
        expect_env(1, 24'h007FFE);
        tick();

        // note_on[3] in voice 3's own service cycle lands on the next sweep.
        expect_env(3, 24'h000000);
        @(negedge clk);
        bus.sample_tick = 1'b1;
        @(negedge clk);
        bus.sample_tick = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        bus.note_on = 4'b1000;
        @(negedge clk);
        bus.note_on = '0;
        repeat (4) @(negedge clk);
        tick_n++;
        expect_env(3, 24'h003FFF);
        tick();

        // Retrigger voice 0 while releasing at 0x800000.
        prm.attack_time   = 7'h00;
        prm.sustain_level = 7'h7F;
        prm.release_time  = 7'h04;
        pulse(4'b0001, 4'b0000);
        expect_env(0, 24'hFFFFFF);
        tick();
        expect_env(0, 24'hFFFFFF);
        tick();
        pulse(4'b0000, 4'b0001);
        expect_env(0, 24'h800000);
        tick();
        prm.attack_time = 7'h2A;
        pulse(4'b0001, 4'b0000);
`ifdef ENVELOPE_BANK_HARD_RETRIGGER_EN
        expect_env(0, 24'h003FFF);
`else
        expect_env(0, 24'h803FFF);
`endif
        tick();

        // Asynchronous reset in the middle of a sweep.
        @(negedge clk);
        bus.sample_tick = 1'b1;
        @(negedge clk);
        bus.sample_tick = 1'b0;
        @(negedge clk);
        chk("busy_before_reset", w_t'(bus.busy), w_t'(1));
        #2;
        rst_l = 1'b0;
        #1;
        chk("midreset_busy", w_t'(bus.busy), w_t'(0));
        chk("midreset_env", w_t'(bus.envelope), w_t'(0));
        chk("midreset_end", w_t'(bus.envelope_end), w_t'(0));
        @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);
        chk("postreset_busy", w_t'(bus.busy), w_t'(0));
        chk("postreset_env", w_t'(bus.envelope), w_t'(0));

        chk("scb_drain", w_t'(scb_q.size()), w_t'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
